// File: rtl/exp_job_scheduler.sv
// ============================================================================
// exp_job_scheduler
// ----------------------------------------------------------------------------
// Multi-requester front end for the pipelined e^x unit. Requesters are
// arbitrated round-robin, the winner's operand is loaded into the pipeline
// through its load handshake, and the issuing requester ID is parked in an
// in-order tag FIFO. The pipeline returns results in issue order, so each
// returned result is paired with the FIFO head and delivered with that ID.
//
// Parameters
//   N_REQ    number of requesters (2..8)
//   MAX_OUT  maximum jobs in flight / tag FIFO depth (power of 2)
//   TIMEOUT  LOAD cycles allowed before a load is aborted
//   IDW      requester ID width
//
// Ports
//   CLK, rst          clock, synchronous active-high reset
//   en                scheduler enable (gates new grants through pl_start)
//   req_valid/data    per-requester job request and float32 operand
//   req_ready         one-hot, one-cycle grant pulse
//   pl_start          registered copy of en, drives the pipeline enable
//   pl_load           load request (LOAD state AND pl_input_ready)
//   pl_float_in       operand held stable for the pipeline
//   pl_input_ready    pipeline can accept a load
//   pl_load_success   pipeline accepted the operand
//   pl_output_ready   one-cycle pulse per completed result
//   pl_float_out      pipeline result
//   rsp_valid/id/data tagged result, one-cycle pulse
//   outstanding       jobs in flight (tag FIFO occupancy)
//   busy              FSM not idle or jobs in flight
//   err_timeout       sticky: a load was aborted
//   err_spurious      sticky: result arrived with no job in flight
// ============================================================================
module exp_job_scheduler #(
    parameter int N_REQ   = 4,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 64,
    parameter int IDW     = $clog2(N_REQ)
) (
    input  logic                       CLK,
    input  logic                       rst,
    input  logic                       en,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [32*N_REQ-1:0]        req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       pl_start,
    output logic                       pl_load,
    output logic [31:0]                pl_float_in,
    input  logic                       pl_input_ready,
    input  logic                       pl_load_success,
    input  logic                       pl_output_ready,
    input  logic [31:0]                pl_float_out,
    output logic                       rsp_valid,
    output logic [IDW-1:0]             rsp_id,
    output logic [31:0]                rsp_data,
    output logic [$clog2(MAX_OUT):0]   outstanding,
    output logic                       busy,
    output logic                       err_timeout,
    output logic                       err_spurious
);

    localparam int             CW   = $clog2(MAX_OUT);
    localparam int             TW   = $clog2(TIMEOUT);
    localparam logic [CW:0]    FULL = (CW+1)'(MAX_OUT);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     r_id;
    logic [31:0]        r_pl_float_in;
    logic               r_pl_start;
    logic [TW-1:0]      r_wait_cnt;

    logic [IDW-1:0]     r_fifo [MAX_OUT];
    logic [CW-1:0]      r_wr_ptr;
    logic [CW-1:0]      r_rd_ptr;
    logic [CW:0]        r_count;

    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [31:0]        r_rsp_data;
    logic               r_err_timeout;
    logic               r_err_spurious;

    logic               w_found;
    logic [IDW-1:0]     w_win_id;
    logic [31:0]        w_win_data;
    logic               w_grant;
    logic               w_push;
    logic               w_abort;
    logic               w_pop;

    // ------------------------------------------------------------------------
    // Round-robin winner: smallest wrap-around distance from r_ptr+1 among
    // the asserted requests.
    // ------------------------------------------------------------------------
    always_comb begin
        int v_dist;
        int v_best;
        // NOTE: every variable written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        v_dist     = 0;
        v_best     = N_REQ;
        w_found    = 1'b0;
        w_win_id   = '0;
        w_win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            v_dist = (i - int'(r_ptr) - 1 + N_REQ) % N_REQ;
            if (req_valid[i] && (v_dist < v_best)) begin
                v_best     = v_dist;
                w_found    = 1'b1;
                w_win_id   = IDW'(i);
                w_win_data = req_data[32*i +: 32];
            end
        end
    end

    // Credit check uses the registered count, so a pop only frees a slot
    // from the following cycle.
    assign w_grant = (r_state == IDLE) && r_pl_start && w_found && (r_count < FULL);
    assign w_push  = (r_state == LOAD) && pl_load_success;
    assign w_abort = (r_state == LOAD) && !pl_load_success
                     && (r_wait_cnt == TW'(TIMEOUT - 1));
    assign w_pop   = pl_output_ready && (r_count != '0);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = '0;
        pl_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    req_ready    = N_REQ'(1) << w_win_id;
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                pl_load = pl_input_ready;
                if (w_push || w_abort) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath, tag FIFO pointers and status
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_ptr          <= IDW'(N_REQ - 1);
            r_id           <= '0;
            r_pl_float_in  <= '0;
            r_pl_start     <= 1'b0;
            r_wait_cnt     <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= '0;
            r_rsp_data     <= '0;
            r_err_timeout  <= 1'b0;
            r_err_spurious <= 1'b0;
        end else begin
            r_pl_start  <= en;
            r_rsp_valid <= w_pop;

            if (w_grant) begin
                r_pl_float_in <= w_win_data;
                r_id          <= w_win_id;
                r_ptr         <= w_win_id;
            end

            if (r_state == LOAD) begin
                if (w_push || w_abort) r_wait_cnt <= '0;
                else                   r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            if (w_abort) r_err_timeout <= 1'b1;
            if (pl_output_ready && (r_count == '0)) r_err_spurious <= 1'b1;

            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_rsp_id   <= r_fifo[r_rd_ptr];
                r_rsp_data <= pl_float_out;
            end

            // Simultaneous push and pop leaves the count unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: tag storage has no reset; entries are only read below the
    // occupancy tracked by the reset pointers, so stale contents are harmless.
    always_ff @(posedge CLK) begin
        if (w_push) r_fifo[r_wr_ptr] <= r_id;
    end

    assign pl_start     = r_pl_start;
    assign pl_float_in  = r_pl_float_in;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_data     = r_rsp_data;
    assign outstanding  = r_count;
    assign busy         = (r_state != IDLE) || (r_count != '0);
    assign err_timeout  = r_err_timeout;
    assign err_spurious = r_err_spurious;

endmodule

// File: tb/tb_exp_job_scheduler.sv
// ============================================================================
// tb_exp_job_scheduler
// ----------------------------------------------------------------------------
// Directed bench for exp_job_scheduler. The bench plays the pipeline: each
// accepted load pushes the expected {requester, result} onto a scoreboard,
// and each result the bench later emits is checked against the scoreboard
// head when rsp_valid appears.
// ============================================================================
module tb_exp_job_scheduler;

    localparam int N_REQ   = 4;
    localparam int MAX_OUT = 4;
    localparam int TIMEOUT = 64;
    localparam int IDW     = 2;

    logic                   CLK = 1'b0;
    logic                   rst;
    logic                   en;
    logic [N_REQ-1:0]       req_valid;
    logic [32*N_REQ-1:0]    req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   pl_start;
    logic                   pl_load;
    logic [31:0]            pl_float_in;
    logic                   pl_input_ready;
    logic                   pl_load_success;
    logic                   pl_output_ready;
    logic [31:0]            pl_float_out;
    logic                   rsp_valid;
    logic [IDW-1:0]         rsp_id;
    logic [31:0]            rsp_data;
    logic [2:0]             outstanding;
    logic                   busy;
    logic                   err_timeout;
    logic                   err_spurious;

    int                     n_checks = 0;
    int                     n_fail   = 0;
    int                     job_seq  = 0;
    logic [31:0]            operand [N_REQ];
    int                     sb_id   [$];
    logic [31:0]            sb_data [$];
    logic [31:0]            pipe_q  [$];

    always #5 CLK = ~CLK;

    exp_job_scheduler #(
        .N_REQ   (N_REQ),
        .MAX_OUT (MAX_OUT),
        .TIMEOUT (TIMEOUT),
        .IDW     (IDW)
    ) dut (
        .CLK             (CLK),
        .rst             (rst),
        .en              (en),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .pl_start        (pl_start),
        .pl_load         (pl_load),
        .pl_float_in     (pl_float_in),
        .pl_input_ready  (pl_input_ready),
        .pl_load_success (pl_load_success),
        .pl_output_ready (pl_output_ready),
        .pl_float_out    (pl_float_out),
        .rsp_valid       (rsp_valid),
        .rsp_id          (rsp_id),
        .rsp_data        (rsp_data),
        .outstanding     (outstanding),
        .busy            (busy),
        .err_timeout     (err_timeout),
        .err_spurious    (err_spurious)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s: observed=empty expected=entry", tag);
    endtask

    // Advance past the next rising edge; inputs are driven here and outputs
    // sampled a further #1 later, well before the next edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] next_res();
        job_seq++;
        return 32'h4100_0000 + 32'(job_seq);
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"},    req_ready,    0);
        check({tag, "_pl_start"},     pl_start,     0);
        check({tag, "_pl_load"},      pl_load,      0);
        check({tag, "_pl_float_in"},  pl_float_in,  0);
        check({tag, "_rsp_valid"},    rsp_valid,    0);
        check({tag, "_outstanding"},  outstanding,  0);
        check({tag, "_busy"},         busy,         0);
        check({tag, "_err_timeout"},  err_timeout,  0);
        check({tag, "_err_spurious"}, err_spurious, 0);
    endtask

    task automatic check_rsp();
        check("rsp_valid", rsp_valid, 1);
        if (sb_id.size() == 0) begin
            fail_now("scoreboard");
        end else begin
            check("rsp_id",   rsp_id,   sb_id.pop_front());
            check("rsp_data", rsp_data, sb_data.pop_front());
        end
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        req_valid       = '0;
        pl_load_success = 1'b0;
        pl_output_ready = 1'b0;
        pl_input_ready  = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        sb_id.delete();
        sb_data.delete();
        pipe_q.delete();
    endtask

    // Wait (bounded) for a grant, check it, then ack the load ack_delay
    // cycles into LOAD. Optionally drop the winner's request once granted
    // and optionally return the oldest result in the ack cycle.
    task automatic issue(input int exp_id, input int ack_delay, input logic [31:0] result,
                         input bit clear_req, input bit pop_with_ack);
        int n;
        logic [N_REQ-1:0] exp_oh;
        n      = 0;
        exp_oh = N_REQ'(1) << exp_id;
        #1;
        while ((req_ready === '0) && (n < 100)) begin
            cyc();
            #1;
            n++;
        end
        check("grant", req_ready, exp_oh);
        cyc();
        if (clear_req) req_valid[exp_id] = 1'b0;
        #1;
        check("grant_pulse", req_ready, 0);
        check("pl_float_in", pl_float_in, operand[exp_id]);
        check("pl_load", pl_load, 1);
        repeat (ack_delay) cyc();
        check("pl_float_in_hold", pl_float_in, operand[exp_id]);
        pl_load_success = 1'b1;
        if (pop_with_ack) begin
            if (pipe_q.size() == 0) fail_now("pipe_q");
            else begin
                pl_output_ready = 1'b1;
                pl_float_out    = pipe_q.pop_front();
            end
        end
        sb_id.push_back(exp_id);
        sb_data.push_back(result);
        pipe_q.push_back(result);
        cyc();
        pl_load_success = 1'b0;
        if (pop_with_ack) begin
            pl_output_ready = 1'b0;
            pl_float_out    = '0;
            #1;
            check_rsp();
        end
    endtask

    task automatic get_result();
        if (pipe_q.size() == 0) begin
            fail_now("pipe_q");
        end else begin
            pl_output_ready = 1'b1;
            pl_float_out    = pipe_q.pop_front();
            cyc();
            pl_output_ready = 1'b0;
            pl_float_out    = '0;
            #1;
            check_rsp();
        end
    endtask

    initial begin
        operand[0] = 32'h3F80_0000;
        operand[1] = 32'h4000_0000;
        operand[2] = 32'hBF80_0000;
        operand[3] = 32'h3F00_0000;
        for (int i = 0; i < N_REQ; i++) req_data[32*i +: 32] = operand[i];
        rst             = 1'b1;
        en              = 1'b0;
        req_valid       = '0;
        pl_input_ready  = 1'b1;
        pl_load_success = 1'b0;
        pl_output_ready = 1'b0;
        pl_float_out    = '0;

        // Reset state
        repeat (3) cyc();
        #1;
        check_zero("reset");
        rst = 1'b0;
        en  = 1'b1;
        cyc();
        #1;
        check("pl_start_follows_en", pl_start, 1);

        // Single job
        req_valid = 4'b0001;
        issue(0, 2, 32'h402D_F854, 1'b1, 1'b0);
        check("single_outstanding", outstanding, 1);
        check("single_busy", busy, 1);
        get_result();
        check("single_drained", outstanding, 0);
        cyc();
        #1;
        check("rsp_valid_pulse", rsp_valid, 0);

        // Round-robin from reset, then credit limit
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) issue(k, 0, next_res(), 1'b0, 1'b0);
        check("credit_outstanding", outstanding, 4);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("credit_no_grant", req_ready, 0);
            check("credit_held", outstanding, 4);
            cyc();
        end
        pl_output_ready = 1'b1;
        pl_float_out    = pipe_q.pop_front();
        #1;
        check("credit_pop_cycle_no_grant", req_ready, 0);
        cyc();
        pl_output_ready = 1'b0;
        pl_float_out    = '0;
        #1;
        check_rsp();
        check("credit_after_pop", outstanding, 3);
        issue(0, 1, next_res(), 1'b1, 1'b0);
        req_valid = '0;
        check("credit_refill", outstanding, 4);
        get_result();
        get_result();
        check("drain_to_two", outstanding, 2);

        // Simultaneous push and pop
        req_valid = 4'b0010;
        issue(1, 1, next_res(), 1'b1, 1'b1);
        check("pushpop_outstanding", outstanding, 2);
        get_result();
        get_result();
        req_valid = 4'b1100;
        issue(2, 0, next_res(), 1'b1, 1'b0);
        issue(3, 0, next_res(), 1'b1, 1'b0);
        get_result();
        get_result();
        check("rr_drained", outstanding, 0);

        // Timeout
        req_valid      = 4'b0011;
        pl_input_ready = 1'b0;
        #1;
        check("to_grant", req_ready, 4'b0001);
        cyc();
        #1;
        check("to_pl_load_low", pl_load, 0);
        check("to_busy", busy, 1);
        repeat (TIMEOUT - 1) cyc();
        #1;
        check("to_not_yet", err_timeout, 0);
        check("to_still_load", req_ready, 0);
        cyc();
        #1;
        check("to_err", err_timeout, 1);
        check("to_outstanding", outstanding, 0);
        check("to_next_grant", req_ready, 4'b0010);
        pl_input_ready = 1'b1;
        req_valid      = 4'b0010;
        issue(1, 0, next_res(), 1'b1, 1'b0);
        get_result();
        check("to_err_sticky", err_timeout, 1);

        // Reset mid-LOAD with three jobs in flight, then a spurious result
        req_valid = 4'b1110;
        issue(2, 0, next_res(), 1'b1, 1'b0);
        issue(3, 0, next_res(), 1'b1, 1'b0);
        issue(1, 0, next_res(), 1'b1, 1'b0);
        req_valid = 4'b0001;
        #1;
        check("mid_grant", req_ready, 4'b0001);
        cyc();
        pl_input_ready = 1'b0;
        #1;
        check("mid_outstanding", outstanding, 3);
        check("mid_busy", busy, 1);
        rst       = 1'b1;
        req_valid = '0;
        cyc();
        #1;
        check_zero("mid_reset");
        rst            = 1'b0;
        pl_input_ready = 1'b1;
        sb_id.delete();
        sb_data.delete();
        pipe_q.delete();
        pl_output_ready = 1'b1;
        pl_float_out    = 32'h1234_5678;
        cyc();
        pl_output_ready = 1'b0;
        pl_float_out    = '0;
        #1;
        check("spurious_no_rsp", rsp_valid, 0);
        check("spurious_err", err_spurious, 1);
        check("spurious_outstanding", outstanding, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
